// File: rtl/i2c_resp_pkg.sv
// Shared constants for the I2C responder: state encoding, ACK/NACK levels,
// synchronizer depth.
package i2c_resp_pkg;
  localparam int SYNC_STAGES = 2;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_ADDR      = 4'd1;
  localparam state_t S_ADDR_ACK  = 4'd2;
  localparam state_t S_PTR       = 4'd3;
  localparam state_t S_PTR_ACK   = 4'd4;
  localparam state_t S_WDATA     = 4'd5;
  localparam state_t S_WDATA_ACK = 4'd6;
  localparam state_t S_RDATA     = 4'd7;
  localparam state_t S_RDATA_ACK = 4'd8;
endpackage

// File: rtl/i2c_resp_sync_edge.sv
// Pin synchronizer followed by a registered rise/fall detector; level output
// is aligned with the edge pulses.
module i2c_sync_edge
  import i2c_resp_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    lvl_d  = sync_q[SYNC_STAGES-1];
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  // Reset to the idle-bus level so release from reset makes no spurious edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/i2c_responder.sv
// I2C target emulating a register-mapped sensor: pointer byte then data bytes
// on writes, auto-incrementing reads; fabric side can preload registers.
module i2c_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         NREGS    = 16,
  parameter int         AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          bus_wr_valid,
  output logic [AW-1:0] bus_wr_addr,
  output logic [7:0]    bus_wr_data,
  output logic          busy
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk), .resetn(resetn), .pin_i(scl_i),
                       .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .resetn(resetn), .pin_i(sda_i),
                       .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d, sh_in;
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic          rw_q, rw_d, ack_q, ack_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic          wr_vld_q, wr_vld_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];
  logic          start, stop;

  assign start   = sda_fall & scl_lvl;
  assign stop    = sda_rise & scl_lvl;
  assign sh_in   = {sh_q[6:0], sda_lvl};
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_d     = ack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start) begin
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          sh_d  = sh_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7 && state_q == S_PTR) ptr_d = sh_in[AW-1:0];
          if (cnt_q == 4'd7 && state_q == S_WDATA) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sh_in;
            ptr_d     = ptr_inc;
          end
        end
        S_RDATA:     cnt_d = cnt_q + 4'd1;
        S_RDATA_ACK: ack_d = sda_lvl;
        default: ;
      endcase
    end else if (scl_fall) begin
      // sda_oe is the inverse of the bit being presented (1 = pull low)
      case (state_q)
        S_ADDR: if (cnt_q == 4'd8) begin
          if (sh_q[7:1] == DEV_ADDR) begin
            state_d  = S_ADDR_ACK;
            sda_oe_d = ~ACK;
            busy_d   = 1'b1;
            rw_d     = sh_q[0];
          end else begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
          end
        end
        S_ADDR_ACK: begin
          cnt_d = 4'd0;
          if (rw_q) begin
            state_d  = S_RDATA;
            sh_d     = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
          end else begin
            state_d  = S_PTR;
            sda_oe_d = 1'b0;
          end
        end
        S_PTR: if (cnt_q == 4'd8) begin
          state_d  = S_PTR_ACK;
          sda_oe_d = ~ACK;
        end
        S_WDATA: if (cnt_q == 4'd8) begin
          state_d  = S_WDATA_ACK;
          sda_oe_d = ~ACK;
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          state_d  = S_WDATA;
          cnt_d    = 4'd0;
          sda_oe_d = 1'b0;
        end
        S_RDATA: if (cnt_q == 4'd8) begin
          state_d  = S_RDATA_ACK;
          sda_oe_d = 1'b0;
        end else begin
          sda_oe_d = ~sh_q[6];
          sh_d     = {sh_q[6:0], 1'b0};
        end
        S_RDATA_ACK: if (ack_q == ACK) begin
          state_d  = S_RDATA;
          cnt_d    = 4'd0;
          ptr_d    = ptr_inc;
          sh_d     = regs_q[ptr_inc];
          sda_oe_d = ~regs_q[ptr_inc][7];
        end else begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Bus write is applied last so it wins over a same-index host write.
  always_comb begin
    regs_d = regs_q;
    if (host_we) regs_d[host_addr] = host_wdata;
    if (wr_vld_d) regs_d[ptr_q] = sh_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      sh_q      <= 8'd0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_q     <= NACK;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q    <= regs_d;
    end
  end

  assign sda_oe       = sda_oe_q;
  assign busy         = busy_q;
  assign bus_wr_valid = wr_vld_q;
  assign bus_wr_addr  = wr_addr_q;
  assign bus_wr_data  = wr_data_q;
endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: bit-banged initiator on an open-drain bus, checked
// against a register/pointer model of the sensor.
module tb_i2c_responder;
  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int Q     = 60;

  logic          clk = 1'b0, resetn = 1'b0, scl_m = 1'b1, drv_low = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'd0;
  logic          sda_oe, bus_wr_valid, busy;
  logic [AW-1:0] bus_wr_addr;
  logic [7:0]    bus_wr_data;
  wire           sda_line = ~(drv_low | sda_oe);

  always #5 clk = ~clk;

  i2c_responder #(.DEV_ADDR(7'h39), .NREGS(NREGS)) dut (
    .clk(clk), .resetn(resetn), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .bus_wr_valid(bus_wr_valid), .bus_wr_addr(bus_wr_addr), .bus_wr_data(bus_wr_data),
    .busy(busy));

  int          vectors = 0, miscompares = 0;
  logic [7:0]  mdl [NREGS];
  int          mptr;
  logic [7:0]  wq [$];
  logic [11:0] exp_q [$], got_q [$];

  always @(negedge clk) if (bus_wr_valid) got_q.push_back({bus_wr_addr, bus_wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_c();
    drv_low = 1'b0; #Q; scl_m = 1'b1; #Q; drv_low = 1'b1; #Q; scl_m = 1'b0; #Q;
  endtask
  task automatic stop_c();
    drv_low = 1'b1; #Q; scl_m = 1'b1; #Q; drv_low = 1'b0; #Q;
  endtask
  task automatic write_bit(input logic b);
    drv_low = ~b; #Q; scl_m = 1'b1; #Q; #Q; scl_m = 1'b0; #Q;
  endtask
  task automatic read_bit(output logic b);
    drv_low = 1'b0; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ackbit);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ackbit);
  endtask
  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    write_bit(nack);
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a[AW-1:0]; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic check_wr();
    logic [11:0] e, g;
    check("wr_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 12'hxxx;
      check("wr_pulse", g, e);
    end
    got_q.delete();
  endtask

  // Write transaction: pointer byte then the bytes queued in wq.
  task automatic tx_write(input logic [7:0] p);
    logic a;
    logic [AW-1:0] pa;
    start_c();
    write_byte(8'h72, a); check("wr_addr_ack", a, 1'b0);
    check("busy_set", busy, 1'b1);
    write_byte(p, a); check("ptr_ack", a, 1'b0);
    mptr = p % NREGS;
    foreach (wq[i]) begin
      write_byte(wq[i], a); check("data_ack", a, 1'b0);
      pa = mptr[AW-1:0];
      mdl[mptr] = wq[i];
      exp_q.push_back({pa, wq[i]});
      mptr = (mptr + 1) % NREGS;
    end
    stop_c();
    check("busy_clr", busy, 1'b0);
    check_wr();
  endtask

  task automatic rd_bytes(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check("rd_data", d, mdl[mptr]);
      if (i != n - 1) mptr = (mptr + 1) % NREGS;
    end
    check("nack_release", sda_oe, 1'b0);
  endtask

  task automatic tx_read(input int n);
    logic a;
    start_c();
    write_byte(8'h73, a); check("rd_addr_ack", a, 1'b0);
    rd_bytes(n);
    stop_c();
    check("busy_clr", busy, 1'b0);
  endtask

  task automatic tx_setptr_read(input logic [7:0] p, input int n);
    logic a;
    start_c();
    write_byte(8'h72, a); check("wr_addr_ack", a, 1'b0);
    write_byte(p, a);     check("ptr_ack", a, 1'b0);
    mptr = p % NREGS;
    start_c();
    write_byte(8'h73, a); check("rd_addr_ack", a, 1'b0);
    rd_bytes(n);
    stop_c();
    check("busy_clr", busy, 1'b0);
    check_wr();
  endtask

  initial begin
    logic       a, b;
    logic [7:0] v;
    int         k, j;
    for (int i = 0; i < NREGS; i++) mdl[i] = 8'd0;
    mptr = 0;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_valid", bus_wr_valid, 1'b0);
    check("rst_wr_addr", bus_wr_addr, '0);
    check("rst_wr_data", bus_wr_data, 8'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    wq = '{8'hA5, 8'h5A};
    tx_write(8'h02);
    tx_setptr_read(8'h02, 2);

    host_write(4, 8'h12);
    host_write(5, 8'h34);
    tx_setptr_read(8'h04, 2);

    // Foreign address: no ACK, nothing after it is taken
    start_c();
    write_byte(8'h74, a); check("bad_addr_nack", a, 1'b1);
    check("bad_addr_busy", busy, 1'b0);
    write_byte(8'h00, a); check("ignored_ack", a, 1'b1);
    write_byte(8'($urandom), a); check("ignored_ack", a, 1'b1);
    stop_c();
    check_wr();

    wq.delete();
    repeat (3) wq.push_back(8'($urandom));
    tx_write(8'h0F);
    wq = '{8'($urandom)};
    tx_write(8'hF3);
    tx_setptr_read(8'h0F, 5);

    repeat (5) begin
      host_write($urandom_range(0, NREGS - 1), 8'($urandom));
      wq.delete();
      repeat ($urandom_range(1, 4)) wq.push_back(8'($urandom));
      tx_write(8'($urandom));
      if ($urandom_range(0, 1) == 1) tx_read($urandom_range(1, 4));
      tx_setptr_read(8'($urandom), $urandom_range(1, 5));
    end

    // STOP part-way through a data byte
    v = 8'($urandom);
    start_c();
    write_byte(8'h72, a); check("wr_addr_ack", a, 1'b0);
    write_byte(v, a);     check("ptr_ack", a, 1'b0);
    mptr = v % NREGS;
    for (int i = 0; i < 4; i++) write_bit(1'($urandom));
    stop_c();
    check("stop_busy", busy, 1'b0);
    check_wr();
    tx_read(2);

    // Reset while the responder holds SDA low in a read byte
    k = $urandom_range(0, NREGS - 1);
    host_write(k, 8'($urandom) & 8'h7F);
    start_c();
    write_byte(8'h72, a); check("wr_addr_ack", a, 1'b0);
    write_byte(8'(k), a); check("ptr_ack", a, 1'b0);
    start_c();
    write_byte(8'h73, a); check("rd_addr_ack", a, 1'b0);
    check("rd_drive_low", sda_oe, 1'b1);
    resetn = 1'b0;
    #1;
    check("rst_async_oe", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < NREGS; i++) mdl[i] = 8'd0;
    mptr = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin read_bit(b); check("post_rst_idle", b, 1'b1); end
    stop_c();
    check("post_rst_wr_addr", bus_wr_addr, '0);
    j = $urandom_range(0, NREGS - 1);
    wq = '{8'($urandom)};
    tx_write(8'(j));
    tx_setptr_read(8'(j), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
